// File: rtl/sig_pkg.sv
// sig_pkg -- shared definitions for the traffic-signal blocks.
//   light_t       : 2-bit light code driven by the signal controller
//   RED/YELLOW/GREEN : light code values
//   sens_state_e  : country-road sensor request states
package sig_pkg;

   typedef logic [1:0] light_t;

   localparam light_t RED    = 2'd0;
   localparam light_t YELLOW = 2'd1;
   localparam light_t GREEN  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      SERVE = 2'd2,
      HOLD  = 2'd3
   } sens_state_e;

endpackage

// File: rtl/cntry_sensor_if.sv
// cntry_sensor_if -- signals between loop pad, signal controller and the
// country-road sensor.
//   loop    : raw inductive-loop detector (asynchronous)
//   hwy     : highway light code observed from the controller
//   cntry   : country light code observed from the controller
//   X       : car-waiting request to the controller
//   car_cnt : cars counted in the current request episode
//   stuck   : stuck-sensor flag
// master = sensor side, slave = controller / pad side.
interface cntry_sensor_if #(
   parameter int CNT_W = 8
);
   import sig_pkg::*;

   logic             loop;
   light_t           hwy;
   light_t           cntry;
   logic             X;
   logic [CNT_W-1:0] car_cnt;
   logic             stuck;

   modport master (input loop, hwy, cntry, output X, car_cnt, stuck);
   modport slave  (output loop, hwy, cntry, input X, car_cnt, stuck);

endinterface

// File: rtl/loop_debounce.sv
// loop_debounce -- two-flop synchronizer plus debounce filter for the loop
// detector.
//   clock    : rising-edge clock
//   clear_n  : asynchronous active-low reset
//   loop     : raw loop input, asynchronous to clock
//   presence : debounced vehicle presence
//   arrive   : one-cycle pulse in the first cycle presence reads 1
module loop_debounce #(
   parameter int DEBOUNCE = 4
) (
   input  logic clock,
   input  logic clear_n,
   input  logic loop,
   output logic presence,
   output logic arrive
);

   localparam int DW = $clog2(DEBOUNCE + 1);

   logic          s1, s2;
   logic [DW-1:0] db_cnt;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         db_cnt   <= '0;
         presence <= 1'b0;
         arrive   <= 1'b0;
      end else begin
         s1     <= loop;
         s2     <= s1;
         arrive <= 1'b0;
         if (s2 != presence) begin
            // the edge whose increment would reach DEBOUNCE flips presence
            if (db_cnt == DW'(DEBOUNCE - 1)) begin
               presence <= s2;
               arrive   <= s2;
               db_cnt   <= '0;
            end else begin
               db_cnt <= db_cnt + DW'(1);
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/cntry_sensor.sv
// cntry_sensor -- country-road vehicle detector feeding the controller's X
// input. Debounces the loop, counts cars per request episode, releases X on
// a traffic gap / green cap / end of country phase, and enforces a minimum
// highway green before requesting again.
//   clock   : rising-edge clock
//   clear_n : asynchronous active-low reset
//   bus     : cntry_sensor_if.master (loop, hwy, cntry in; X, car_cnt, stuck out)
// Optional feature: define STUCK_DET_EN to build the stuck-sensor detector;
// otherwise stuck is tied to 0.
module cntry_sensor
   import sig_pkg::*;
#(
   parameter int DEBOUNCE     = 4,
   parameter int GAP          = 8,
   parameter int MAX_GREEN    = 32,
   parameter int MIN_HWY      = 16,
   parameter int CNT_W        = 8,
   parameter int STUCK_CYCLES = 256
) (
   input  logic           clock,
   input  logic           clear_n,
   cntry_sensor_if.master bus
);

   localparam int GW = $clog2(GAP + 1);
   localparam int MW = $clog2(MAX_GREEN + 1);
   localparam int HW = $clog2(MIN_HWY + 1);

   if (DEBOUNCE < 1 || GAP < 1 || MAX_GREEN < 1 || MIN_HWY < 1 || STUCK_CYCLES < 1)
   begin : g_param_chk
      $error("cntry_sensor: timing parameters must be >= 1");
   end

   sens_state_e      state;
   logic [GW-1:0]    gap_cnt;
   logic [MW-1:0]    green_cnt;
   logic [HW-1:0]    hold_cnt;
   logic [CNT_W-1:0] car_cnt;
   logic             pend;
   logic             presence, arrive;
   logic             stuck_blk;
   logic             hwy_window;

   loop_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clock    (clock),
      .clear_n  (clear_n),
      .loop     (bus.loop),
      .presence (presence),
      .arrive   (arrive)
   );

`ifdef STUCK_DET_EN
   localparam int SW = $clog2(STUCK_CYCLES + 1);
   logic [SW-1:0] stuck_cnt;
   logic          stuck_q;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         stuck_cnt <= '0;
         stuck_q   <= 1'b0;
      end else if (!presence) begin
         stuck_cnt <= '0;
         stuck_q   <= 1'b0;
      end else if (!stuck_q) begin
         if (stuck_cnt == SW'(STUCK_CYCLES - 1))
            stuck_q <= 1'b1;
         stuck_cnt <= stuck_cnt + SW'(1);
      end
   end

   assign stuck_blk = stuck_q;
`else
   assign stuck_blk = 1'b0;
`endif

   // highway actually flowing while the country side is stopped
   assign hwy_window = (bus.hwy == GREEN) && (bus.cntry == RED);

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state     <= IDLE;
         gap_cnt   <= '0;
         green_cnt <= '0;
         hold_cnt  <= '0;
         car_cnt   <= '0;
         pend      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (presence && !stuck_blk) begin
                  state   <= ARMED;
                  car_cnt <= CNT_W'(1);
               end
            end
            ARMED: begin
               gap_cnt   <= '0;
               green_cnt <= '0;
               if (arrive && car_cnt != '1)
                  car_cnt <= car_cnt + CNT_W'(1);
               if (bus.cntry == GREEN)
                  state <= SERVE;
            end
            SERVE: begin
               green_cnt <= green_cnt + MW'(1);
               gap_cnt   <= presence ? '0 : gap_cnt + GW'(1);
               // an arrival on the exit edge still belongs to this episode
               if (arrive && car_cnt != '1)
                  car_cnt <= car_cnt + CNT_W'(1);
               if (bus.cntry != GREEN ||
                   green_cnt == MW'(MAX_GREEN - 1) ||
                   (!presence && gap_cnt == GW'(GAP - 1))) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
                  pend     <= 1'b0;
               end
            end
            HOLD: begin
               if (arrive)
                  pend <= 1'b1;
               if (!hwy_window) begin
                  hold_cnt <= '0;
               end else if (hold_cnt == HW'(MIN_HWY - 1)) begin
                  hold_cnt <= '0;
                  pend     <= 1'b0;
                  if ((presence || pend) && !stuck_blk) begin
                     state   <= ARMED;
                     car_cnt <= CNT_W'(1);
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.X       = (state == ARMED) || (state == SERVE);
   assign bus.car_cnt = car_cnt;
   assign bus.stuck   = stuck_blk;

endmodule
